hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Drives the enable, flush and bubble inputs of the IF/ID and ID/EX pipeline registers and the PC write enable.
- Detects load-use hazards and redirects from taken branches or jumps, and freezes the pipe while data memory is busy.
- Sits beside the decode stage.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
LOAD_STALLS, 1, bubble cycles inserted per load-use hazard (1..3)
FLUSH_CYCLES, 1, cycles the IF/ID and ID/EX flush is held after a redirect (1..3)
CNT_W, 16, width of the performance counters

Ports:
ck  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_memread  input  1  instruction in EX is a load
ex_regdst  input  5  destination register of the EX instruction
branch_taken  input  1  EX resolved a taken branch
jump_taken  input  1  EX resolved a jump
mem_busy  input  1  data memory not ready; whole pipe must hold
pc_en  output  1  PC write enable
ifid_en  output  1  IF/ID register enable
idex_en  output  1  ID/EX register enable
ifid_flush  output  1  load NOP into IF/ID
idex_flush  output  1  load NOP into ID/EX
idex_bubble  output  1  zero all ID/EX control fields (regwrt, memread, memwrite, branches, jumps)
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  redirect flush cycles, saturating

Behaviour:
- States: RUN, LU_STALL, FLUSH, MEM_WAIT. A down-counter cnt (2 bits) tracks the remaining stall or flush cycles.
- Outputs are Mealy: combinational from state and current inputs. The state, cnt and counters register on the rising edge of ck.
- Reset behaviour:
  - rst high at an edge sets state=RUN, cnt=0, stall_cnt=0 and flush_cnt=0.
  - While rst is high, outputs are forced to pc_en=ifid_en=idex_en=0 and ifid_flush=idex_flush=idex_bubble=1.
  - rst mid-stall or mid-flush abandons the remaining cycles.
- Hazard definition: lu = ex_memread && ex_regdst!=0 && ((id_uses_rs && id_rs==ex_regdst) || (id_uses_rt && id_rt==ex_regdst)). Register 0 never hazards.
- Event priority within a cycle: mem_busy > redirect (branch_taken|jump_taken) > lu.
- Normal flow (RUN, no event): all enables=1, all flushes=0, bubble=0.
- Load-use (RUN, lu):
  - Outputs: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
  - stall_cnt increments.
  - If LOAD_STALLS>1, go to LU_STALL with cnt=LOAD_STALLS-1; else stay in RUN.
- LU_STALL: same outputs as the load-use cycle. cnt decrements each cycle; go to RUN when cnt reaches 1→0. stall_cnt increments each cycle.
- Redirect (RUN or LU_STALL, branch_taken|jump_taken):
  - Outputs: pc_en=1 (PC loads the target), ifid_en=idex_en=1, ifid_flush=idex_flush=1, bubble=1.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; else go to RUN.
  - A redirect cancels a pending load-use stall.
- FLUSH:
  - Outputs: pc_en=1, enables=1, ifid_flush=idex_flush=1. flush_cnt increments each cycle.
  - Go to RUN when cnt expires.
  - A new redirect in FLUSH reloads cnt=FLUSH_CYCLES-1.
- mem_busy (any state):
  - All enables=0, flushes=0, bubble=0 (pure freeze). Go to MEM_WAIT, preserving the prior state and cnt in a saved register.
  - Counters do not change.
  - On the first cycle mem_busy=0, restore the saved state and evaluate it in that same cycle.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- Reset → rst=1 for 2 cycles with lu conditions present → pc_en=0, ifid_en=0, idex_en=0, all flush/bubble=1, stall_cnt=0. Release rst with no hazard → next cycle all enables=1.
- Load-use, LOAD_STALLS=1 → ex_memread=1, ex_regdst=5, id_rs=5, id_uses_rs=1 for one cycle → exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1. stall_cnt goes 0→1. Repeat with ex_regdst=0 → no stall.
- Load-use, LOAD_STALLS=2 → same stimulus, lu deasserted after the first cycle → 2 consecutive stall cycles, stall_cnt=2.
- Redirect, FLUSH_CYCLES=2 → branch_taken pulse for 1 cycle → 2 cycles with ifid_flush=idex_flush=1 and pc_en=1, flush_cnt=2. A simultaneous lu in the redirect cycle produces no stall.
- Memory freeze → mem_busy held 3 cycles during LU_STALL (cnt=1) → 3 cycles with all enables=0 and counters frozen. Then 1 remaining stall cycle follows, then RUN.
- Saturation, CNT_W=4 → 20 consecutive load-use hazards → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard/stall control bus: hazard sources in, pipeline-register
// controls and performance counters out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_regdst;
  logic             branch_taken;
  logic             jump_taken;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_regdst,
           branch_taken, jump_taken, mem_busy,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, idex_bubble,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_regdst,
           branch_taken, jump_taken, mem_busy,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, idex_bubble,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, redirect flushes and
// memory-busy freeze with saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int LOAD_STALLS  = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                ck,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_e;

  localparam logic [1:0]       LS_RELOAD = 2'(LOAD_STALLS - 1);
  localparam logic [1:0]       FC_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d, saved_state_q, saved_state_d, eff_state;
  logic [1:0]       cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu, redirect;
  logic             pc_en, ifid_en, idex_en, ifid_flush, idex_flush, idex_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    lu = bus.ex_memread && (bus.ex_regdst != 5'd0) &&
         ((bus.id_uses_rs && (bus.id_rs == bus.ex_regdst)) ||
          (bus.id_uses_rt && (bus.id_rt == bus.ex_regdst)));
    redirect = bus.branch_taken | bus.jump_taken;

    // Leaving MEM_WAIT resumes the saved state within the same cycle.
    eff_state = (state_q == MEM_WAIT) ? saved_state_q : state_q;
    eff_cnt   = (state_q == MEM_WAIT) ? saved_cnt_q   : cnt_q;

    state_d       = eff_state;
    cnt_d         = eff_cnt;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    idex_bubble   = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      state_d       = MEM_WAIT;
      cnt_d         = cnt_q;
      saved_state_d = eff_state;
      saved_cnt_d   = eff_cnt;
    end else if (redirect && (eff_state != MEM_WAIT)) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_cnt_d = sat_inc(flush_cnt_q);
      state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_d       = (FLUSH_CYCLES > 1) ? FC_RELOAD : 2'd0;
    end else begin
      case (eff_state)
        RUN: begin
          if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            state_d     = (LOAD_STALLS > 1) ? LU_STALL : RUN;
            cnt_d       = (LOAD_STALLS > 1) ? LS_RELOAD : 2'd0;
          end
        end
        LU_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          cnt_d       = eff_cnt - 2'd1;
          state_d     = (eff_cnt <= 2'd1) ? RUN : LU_STALL;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
          cnt_d       = eff_cnt - 2'd1;
          state_d     = (eff_cnt <= 2'd1) ? RUN : FLUSH;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      saved_state_q <= RUN;
      saved_cnt_q   <= 2'd0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations share one stimulus
// stream and are compared each cycle against a remaining-cycles model.
module tb_hazard_stall_ctrl;

  logic       ck = 1'b0;
  logic       rst, mb, br, jp, mr, urs, urt;
  logic [4:0] dst, rs, rt;

  int checks   = 0;
  int failures = 0;

  localparam int LSP [3] = '{1, 2, 3};
  localparam int FCP [3] = '{2, 1, 3};
  localparam int CWP [3] = '{4, 16, 16};

  int          stall_left [3];
  int          flush_left [3];
  int unsigned m_sc [3];
  int unsigned m_fc [3];

  always #5 ck = ~ck;

  hazard_stall_ctrl_if #(.CNT_W(4))  i0 ();
  hazard_stall_ctrl_if #(.CNT_W(16)) i1 ();
  hazard_stall_ctrl_if #(.CNT_W(16)) i2 ();

  hazard_stall_ctrl #(.LOAD_STALLS(1), .FLUSH_CYCLES(2), .CNT_W(4))
    d0 (.ck(ck), .rst(rst), .bus(i0.slave));
  hazard_stall_ctrl #(.LOAD_STALLS(2), .FLUSH_CYCLES(1), .CNT_W(16))
    d1 (.ck(ck), .rst(rst), .bus(i1.slave));
  hazard_stall_ctrl #(.LOAD_STALLS(3), .FLUSH_CYCLES(3), .CNT_W(16))
    d2 (.ck(ck), .rst(rst), .bus(i2.slave));

  assign i0.id_rs = rs;  assign i1.id_rs = rs;  assign i2.id_rs = rs;
  assign i0.id_rt = rt;  assign i1.id_rt = rt;  assign i2.id_rt = rt;
  assign i0.id_uses_rs = urs;  assign i1.id_uses_rs = urs;  assign i2.id_uses_rs = urs;
  assign i0.id_uses_rt = urt;  assign i1.id_uses_rt = urt;  assign i2.id_uses_rt = urt;
  assign i0.ex_memread = mr;  assign i1.ex_memread = mr;  assign i2.ex_memread = mr;
  assign i0.ex_regdst = dst;  assign i1.ex_regdst = dst;  assign i2.ex_regdst = dst;
  assign i0.branch_taken = br;  assign i1.branch_taken = br;  assign i2.branch_taken = br;
  assign i0.jump_taken = jp;  assign i1.jump_taken = jp;  assign i2.jump_taken = jp;
  assign i0.mem_busy = mb;  assign i1.mem_busy = mb;  assign i2.mem_busy = mb;

  function automatic logic [5:0] dut_out(input int k);
    case (k)
      0: return {i0.pc_en, i0.ifid_en, i0.idex_en, i0.ifid_flush, i0.idex_flush, i0.idex_bubble};
      1: return {i1.pc_en, i1.ifid_en, i1.idex_en, i1.ifid_flush, i1.idex_flush, i1.idex_bubble};
      default: return {i2.pc_en, i2.ifid_en, i2.idex_en, i2.ifid_flush, i2.idex_flush, i2.idex_bubble};
    endcase
  endfunction

  function automatic logic [31:0] dut_sc(input int k);
    case (k)
      0: return 32'(i0.stall_cnt);
      1: return 32'(i1.stall_cnt);
      default: return 32'(i2.stall_cnt);
    endcase
  endfunction

  function automatic logic [31:0] dut_fc(input int k);
    case (k)
      0: return 32'(i0.flush_cnt);
      1: return 32'(i1.flush_cnt);
      default: return 32'(i2.flush_cnt);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned bump(input int unsigned v, input int w);
    int unsigned top;
    top = (32'd1 << w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  // Expected outputs {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, idex_bubble}.
  task automatic model_step(input int k, input int cyc);
    logic [5:0] exp;
    logic       hz;
    hz = mr && (dst != 0) && ((urs && rs == dst) || (urt && rt == dst));
    check($sformatf("ctl%0d_c%0d", k, cyc), 32'(dut_out(k)), 32'(rst ? 6'b000111 :
          mb ? 6'b000000 : (br || jp) ? 6'b111111 : (flush_left[k] > 0) ? 6'b111110 :
          (stall_left[k] > 0 || hz) ? 6'b001001 : 6'b111000));
    check($sformatf("stall%0d_c%0d", k, cyc), dut_sc(k), m_sc[k]);
    check($sformatf("flush%0d_c%0d", k, cyc), dut_fc(k), m_fc[k]);
    exp = 6'b0;
    if (rst) begin
      stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else if (mb) begin
      exp = 6'b0;
    end else if (br || jp) begin
      m_fc[k] = bump(m_fc[k], CWP[k]);
      flush_left[k] = FCP[k] - 1;
      stall_left[k] = 0;
    end else if (flush_left[k] > 0) begin
      m_fc[k] = bump(m_fc[k], CWP[k]);
      flush_left[k]--;
    end else if (stall_left[k] > 0) begin
      m_sc[k] = bump(m_sc[k], CWP[k]);
      stall_left[k]--;
    end else if (hz) begin
      m_sc[k] = bump(m_sc[k], CWP[k]);
      stall_left[k] = LSP[k] - 1;
    end
  endtask

  int cyc = 0;

  task automatic step(input logic r, input logic b, input logic j, input logic m,
                      input logic rd, input logic [4:0] d, input logic [4:0] s,
                      input logic [4:0] t, input logic us, input logic ut);
    rst = r; br = b; jp = j; mb = m; mr = rd; dst = d; rs = s; rt = t; urs = us; urt = ut;
    @(negedge ck);
    for (int k = 0; k < 3; k++) model_step(k, cyc);
    cyc++;
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic lu_step();
    step(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    rst = 1; br = 0; jp = 0; mb = 0; mr = 0; dst = 0; rs = 0; rt = 0; urs = 0; urt = 0;
    @(posedge ck);
    #1;
    // Reset held with a load-use hazard present, then release.
    step(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    step(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    idle();
    // Load-use pulse via rs, then via rt, then against r0.
    lu_step(); idle(); idle(); idle();
    step(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1); idle(); idle(); idle();
    step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1); idle();
    // Taken branch with a simultaneous load-use, then a jump.
    step(0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0); idle(); idle(); idle();
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); idle(); idle(); idle();
    // Redirect cancelling a pending stall; redirect re-arming a flush.
    lu_step(); step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); idle(); idle(); idle();
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); idle(); idle(); idle();
    // Memory freeze in the middle of a stall.
    lu_step(); idle();
    repeat (3) step(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 0);
    idle(); idle(); idle();
    // Saturation of the 4-bit counter.
    repeat (20) lu_step();
    idle(); idle(); idle();
    repeat (20) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(); idle(); idle();
    // Reset in the middle of a stall and a flush.
    lu_step(); step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); idle(); idle();
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); idle(); idle();
    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 45, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
